tlb_op_unit: RTL
================

# tlb_op_unit

- Sequences the CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) for the core.
- Sits directly upstream of the TLB array:
  - drives the TLB write port;
  - scans entries through a TLB read port;
  - returns probe and read results to CP0.
- Owns the CP0 Random counter.

## Interface

Parameters: none; the TLB has 16 entries.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- op_valid_i  in  1  operation request
- op_i  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- op_ready_o  out  1  high in IDLE; a request is accepted when op_valid_i & op_ready_o
- done_o  out  1  one-cycle completion pulse
- cp0_entryhi_i, cp0_entrylo0_i, cp0_entrylo1_i, cp0_index_i  in  32  CP0 register values
- cp0_wired_i  in  32  Wired register; only [3:0] is used
- wired_we_i  in  1  Wired is being written this cycle
- random_o  out  4  current Random value
- tlb_wr_o  out  1  TLB write strobe
- tlb_index_o  out  4  write index
- tlb_entryhi_o, tlb_entrylo0_o, tlb_entrylo1_o  out  32  write data
- tlb_rd_idx_o  out  4  read index; the read port is combinational
- tlb_rd_entryhi_i  in  32  {vpn2[31:13], 5'b0, asid[7:0]}
- tlb_rd_entrylo0_i, tlb_rd_entrylo1_i  in  32  {6'b0, pfn, opts[5:1], g}
- index_we_o  out  1  CP0 Index write strobe
- index_o  out  32  Index write data
- entry_we_o  out  1  EntryHi/EntryLo0/EntryLo1 write strobe
- entryhi_o, entrylo0_o, entrylo1_o  out  32  read-back data
- mcheck_o  out  1  duplicate-entry machine check pulse

## Operation

FSM states: IDLE, PROBE, READ, WRITE, CHECK (CHECK exists only with the macro), DONE.

Accept and snapshot:
- In IDLE with op_valid_i high, the request is accepted at the clock edge.
- cp0_* inputs and random_o are snapshotted at accept.
- Requests are ignored while op_ready_o is low.

TLBP:
- Scans idx 0..15, one entry per cycle, with tlb_rd_idx_o = idx.
- Match condition: vpn2 equal AND (g0 & g1, or asid equal).
- First match k: index_o = {28'b0, k}.
- No match after idx 15: index_o = 32'h8000_0000.
- Result is written via index_we_o.

TLBR:
- Reads from tlb_rd_idx_o = index[3:0].
- entryhi_o = tlb_rd_entryhi_i.
- entrylo0_o / entrylo1_o = read data, with bit0 replaced by g0 & g1.
- Result is written via entry_we_o.

TLBWI / TLBWR:
- tlb_wr_o pulses for one cycle.
- tlb_index_o = index[3:0] for TLBWI, or the snapshotted Random for TLBWR.
- Write data = the snapshotted EntryHi/Lo0/Lo1.

Random counter:
- Reset value 15.
- Decrements by 1 every cycle.
- When random_o <= wired[3:0], the next value is 15 (wrap).
- wired_we_i forces 15 the next cycle; this takes priority over the decrement.
- With wired[3:0] = 15, random_o stays at 15.
- Random never stops, including during operations.

Reset values (asynchronous assertion, any state):
- FSM returns to IDLE.
- random_o = 15; op_ready_o = 1.
- All other outputs are 0.
- An in-flight operation is abandoned with no write and no done_o.

## Timing

Cycle 0 is the accept edge.

- TLBP, hit at idx k: idx k is compared in cycle k+1; done_o and index_we_o are high in cycle k+2.
- TLBP, miss: done_o and index_we_o are high in cycle 17.
- TLBR: read in cycle 1; done_o and entry_we_o are high in cycle 2.
- TLBWI / TLBWR (no macro): tlb_wr_o is high in cycle 1; done_o is high in cycle 2.
- op_ready_o goes high in the cycle after done_o. A back-to-back request can be accepted on that edge.
- Result outputs (index_o, entry*_o) hold their value until the next completion.

## Configuration

TLB_MCHECK_EN:
- Defined:
  - TLBWI/TLBWR first enter CHECK.
  - CHECK scans all 16 entries except the target index, using the TLBP match rule against the snapshotted EntryHi.
  - On a duplicate at scanned position j: mcheck_o and done_o pulse together in the cycle after the compare; no write occurs.
  - With no duplicate: the scan takes cycles 1..16, tlb_wr_o is high in cycle 17, and done_o is high in cycle 18.
- Undefined: the CHECK state is absent and mcheck_o is tied to 0.

## Test plan

- Reset, then release with wired = 3:
  - random_o sequence is 15, 14, …, 3, 15, 14, …;
  - wired_we_i forces 15 the next cycle.
- TLBWI with index = 5, EntryHi = 32'h0040_2011, Lo0 = 32'h0000_1047, Lo1 = 32'h0000_1087:
  - tlb_wr_o in cycle 1 with tlb_index_o = 5;
  - done_o in cycle 2.
- TLBP with the model holding that entry at idx 5:
  - index_o = 32'h0000_0005 in cycle 7.
- TLBP with the ASID mismatched and g = 0:
  - index_o = 32'h8000_0000 in cycle 17.
  - Repeat with g = 1: hit.
- TLBR of index 5:
  - entryhi_o = 32'h0040_2011 in cycle 2;
  - entrylo0_o bit0 = g0 & g1.
- Stress:
  - TLBWR after a 7-cycle wait: written index equals the random_o value at accept.
  - Reset asserted in cycle 3 of a TLBP: no done_o, op_ready_o = 1.
  - With TLB_MCHECK_EN: a duplicate VPN2 write gives an mcheck_o pulse and no tlb_wr_o.

Source files
------------

// File: rtl/tlb_op_unit.sv
// tlb_op_unit: sequences TLBP/TLBR/TLBWI/TLBWR against a 16-entry TLB and owns CP0 Random.
// Define TLB_MCHECK_EN to add a duplicate-entry scan (machine check) before every TLB write.
module tlb_op_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        op_valid_i,
  input  logic [1:0]  op_i,
  output logic        op_ready_o,
  output logic        done_o,
  input  logic [31:0] cp0_entryhi_i,
  input  logic [31:0] cp0_entrylo0_i,
  input  logic [31:0] cp0_entrylo1_i,
  input  logic [31:0] cp0_index_i,
  input  logic [31:0] cp0_wired_i,
  input  logic        wired_we_i,
  output logic [3:0]  random_o,
  output logic        tlb_wr_o,
  output logic [3:0]  tlb_index_o,
  output logic [31:0] tlb_entryhi_o,
  output logic [31:0] tlb_entrylo0_o,
  output logic [31:0] tlb_entrylo1_o,
  output logic [3:0]  tlb_rd_idx_o,
  input  logic [31:0] tlb_rd_entryhi_i,
  input  logic [31:0] tlb_rd_entrylo0_i,
  input  logic [31:0] tlb_rd_entrylo1_i,
  output logic        index_we_o,
  output logic [31:0] index_o,
  output logic        entry_we_o,
  output logic [31:0] entryhi_o,
  output logic [31:0] entrylo0_o,
  output logic [31:0] entrylo1_o,
  output logic        mcheck_o
);
  typedef enum logic [2:0] {
    IDLE, PROBE, READ, WRITE, DONE
`ifdef TLB_MCHECK_EN
    , CHECK
`endif
  } state_t;
`ifdef TLB_MCHECK_EN
  localparam state_t WR_ENTRY = CHECK;
  logic mchk_q;
`else
  localparam state_t WR_ENTRY = WRITE;
`endif
  state_t state_q, state_d;
  logic [3:0] rnd_q, rnd_d, idx_q, tgt_q;
  logic [1:0] op_q;
  logic [31:0] ehi_q, lo0_q, lo1_q, index_q, entryhi_q, entrylo0_q, entrylo1_q;
  logic accept, last, hit, g;
  logic unused_ok;
  assign unused_ok = ^{cp0_index_i[31:4], cp0_wired_i[31:4]};
  assign accept = op_valid_i & op_ready_o;
  assign last = idx_q == 4'd15;
  assign g = tlb_rd_entrylo0_i[0] & tlb_rd_entrylo1_i[0];
  assign hit = tlb_rd_entryhi_i[31:13] == ehi_q[31:13] && (g || tlb_rd_entryhi_i[7:0] == ehi_q[7:0]);
  // Wired writes and the wired boundary both restart Random at the top
  assign rnd_d = (wired_we_i || rnd_q <= cp0_wired_i[3:0]) ? 4'd15 : rnd_q - 4'd1;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) rnd_q <= 4'd15;
    else rnd_q <= rnd_d;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = !accept ? IDLE : op_i == 2'b00 ? PROBE : op_i == 2'b01 ? READ : WR_ENTRY;
      PROBE:       state_d = (hit || last) ? DONE : PROBE;
      READ, WRITE: state_d = DONE;
`ifdef TLB_MCHECK_EN
      CHECK:       state_d = (hit && idx_q != tgt_q) ? DONE : last ? WRITE : CHECK;
`endif
      default:     state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      op_q <= '0;
      idx_q <= '0;
      tgt_q <= '0;
      ehi_q <= '0;
      lo0_q <= '0;
      lo1_q <= '0;
      index_q <= '0;
      entryhi_q <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
`ifdef TLB_MCHECK_EN
      mchk_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q <= op_i;
        idx_q <= '0;
        tgt_q <= op_i == 2'b11 ? rnd_q : cp0_index_i[3:0];
        ehi_q <= cp0_entryhi_i;
        lo0_q <= cp0_entrylo0_i;
        lo1_q <= cp0_entrylo1_i;
`ifdef TLB_MCHECK_EN
        mchk_q <= 1'b0;
`endif
      end
      if (state_q == PROBE) idx_q <= idx_q + 4'd1;
      if (state_q == PROBE && (hit || last)) index_q <= hit ? {28'd0, idx_q} : 32'h8000_0000;
      if (state_q == READ) begin
        entryhi_q <= tlb_rd_entryhi_i;
        entrylo0_q <= {tlb_rd_entrylo0_i[31:1], g};
        entrylo1_q <= {tlb_rd_entrylo1_i[31:1], g};
      end
`ifdef TLB_MCHECK_EN
      // The target slot itself may legally hold the same VPN2; skip it
      if (state_q == CHECK) begin
        idx_q <= idx_q + 4'd1;
        if (hit && idx_q != tgt_q) mchk_q <= 1'b1;
      end
`endif
    end
  always_comb begin
    op_ready_o = state_q == IDLE;
    done_o = state_q == DONE;
    tlb_wr_o = state_q == WRITE;
    index_we_o = state_q == DONE && op_q == 2'b00;
    entry_we_o = state_q == DONE && op_q == 2'b01;
    tlb_rd_idx_o = state_q == READ ? tgt_q : idx_q;
`ifdef TLB_MCHECK_EN
    mcheck_o = state_q == DONE && mchk_q;
`else
    mcheck_o = 1'b0;
`endif
  end
  assign random_o = rnd_q;
  assign tlb_index_o = tgt_q;
  assign tlb_entryhi_o = ehi_q;
  assign tlb_entrylo0_o = lo0_q;
  assign tlb_entrylo1_o = lo1_q;
  assign index_o = index_q;
  assign entryhi_o = entryhi_q;
  assign entrylo0_o = entrylo0_q;
  assign entrylo1_o = entrylo1_q;
endmodule
